// File: rtl/cpu_pkg.sv
// Constants and types shared by the fetch, decode and execute stages.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam int          IROM_AW  = 14;

  typedef enum logic [1:0] {
    FETCH_RESET,
    FETCH_REDIRECT,
    FETCH_STALL,
    FETCH_RUN
  } fetch_action_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] return_pc;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    inst:      NOP_INST,
    pc:        32'h0000_0000,
    return_pc: 32'h0000_0000,
    valid:     1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush load a bubble, hold freezes it,
// otherwise it captures the fetched instruction and its PC/link value.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] return_pc_o,
  output logic        valid_o
);

  if_id_t r_if_id;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i || bubble_i) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (!hold_i) begin
      r_if_id <= '{
        inst:      inst_i,
        pc:        pc_i,
        return_pc: pc_i + PC_STEP,
        valid:     1'b1
      };
    end
  end

  assign inst_o      = r_if_id.inst;
  assign pc_o        = r_if_id.pc;
  assign return_pc_o = r_if_id.return_pc;
  assign valid_o     = r_if_id.valid;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection, ROM addressing and
// the IF/ID register, with load-use stall and EX-stage redirect handling.
module inst_fetch
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IROM_AW-1:0] irom_addr_o,
  input  logic [31:0]        irom_inst_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        id_inst_o,
  output logic [31:0]        id_pc_o,
  output logic [31:0]        id_return_pc_o,
  output logic               id_valid_o,
  output logic               misalign_o
);

  logic [31:0]   r_pc;
  logic          r_misalign;
  fetch_action_e w_action;
  logic [31:0]   w_pc_next;
  logic          w_misalign_next;

  // Redirect outranks stall: the branch in EX is older than the stalled pair.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_action        = FETCH_RUN;
    w_pc_next       = r_pc + PC_STEP;
    w_misalign_next = r_misalign;
    if (reset_i) begin
      w_action        = FETCH_RESET;
      w_pc_next       = RESET_PC;
      w_misalign_next = 1'b0;
    end else if (redirect_i) begin
      w_action        = FETCH_REDIRECT;
      w_pc_next       = {redirect_pc_i[31:2], 2'b00};
      w_misalign_next = r_misalign | (redirect_pc_i[1:0] != 2'b00);
    end else if (stall_i) begin
      w_action        = FETCH_STALL;
      w_pc_next       = r_pc;
    end
  end

  // NOTE: only the small architectural registers are reset; there is no
  // storage array here that would need clearing.
  always_ff @(posedge clk_i) begin
    r_pc       <= w_pc_next;
    r_misalign <= w_misalign_next;
  end

  if_id_reg u_if_id_reg (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .hold_i      (w_action == FETCH_STALL),
    .bubble_i    (w_action == FETCH_REDIRECT),
    .inst_i      (irom_inst_i),
    .pc_i        (r_pc),
    .inst_o      (id_inst_o),
    .pc_o        (id_pc_o),
    .return_pc_o (id_return_pc_o),
    .valid_o     (id_valid_o)
  );

  assign pc_o        = r_pc;
  assign irom_addr_o = r_pc[IROM_AW+1:2];
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; the ROM model returns 32'h1000_0000 + word.
module tb_inst_fetch;

  localparam int AW = 14;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          stall_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic [AW-1:0] irom_addr_o;
  logic [31:0]   irom_inst_i;
  logic [31:0]   pc_o;
  logic [31:0]   id_inst_o;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_return_pc_o;
  logic          id_valid_o;
  logic          misalign_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign irom_inst_i = 32'h1000_0000 + {18'd0, irom_addr_o};

  inst_fetch dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .irom_addr_o    (irom_addr_o),
    .irom_inst_i    (irom_inst_i),
    .pc_o           (pc_o),
    .id_inst_o      (id_inst_o),
    .id_pc_o        (id_pc_o),
    .id_return_pc_o (id_return_pc_o),
    .id_valid_o     (id_valid_o),
    .misalign_o     (misalign_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_inst"}, id_inst_o, 32'h0000_0013);
    check({tag, "_valid"}, {31'd0, id_valid_o}, 32'd0);
    check({tag, "_pc"}, id_pc_o, 32'd0);
    check({tag, "_ret"}, id_return_pc_o, 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    step(); step();
    check("rst_pc", pc_o, 32'd0);
    check_bubble("rst");
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);

    // free run
    reset_i = 1'b0;
    step();
    check("run1_inst", id_inst_o, 32'h1000_0000);
    check("run1_pc", id_pc_o, 32'd0);
    check("run1_ret", id_return_pc_o, 32'd4);
    check("run1_valid", {31'd0, id_valid_o}, 32'd1);
    check("run1_ifpc", pc_o, 32'd4);
    step();
    check("run2_inst", id_inst_o, 32'h1000_0001);
    check("run2_pc", id_pc_o, 32'd4);
    step();
    check("run3_pc", id_pc_o, 32'd8);
    check("run3_addr", {18'd0, irom_addr_o}, 32'd3);

    // stall 3 cycles
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_idpc", id_pc_o, 32'd8);
      check("stall_inst", id_inst_o, 32'h1000_0002);
      check("stall_addr", {18'd0, irom_addr_o}, 32'd3);
    end
    stall_i = 1'b0;
    step();
    check("unstall_pc", id_pc_o, 32'd12);
    check("unstall_inst", id_inst_o, 32'h1000_0003);
    check("unstall_ifpc", pc_o, 32'd16);

    // redirect to 0x40 from pc 16
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step();
    check_bubble("redir");
    check("redir_ifpc", pc_o, 32'h40);
    redirect_i = 1'b0;
    step();
    check("redir_tgt_pc", id_pc_o, 32'h40);
    check("redir_tgt_inst", id_inst_o, 32'h1000_0010);
    check("redir_tgt_valid", {31'd0, id_valid_o}, 32'd1);
    check("redir_tgt_ret", id_return_pc_o, 32'h44);

    // stall and redirect together
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80;
    step();
    check("both_ifpc", pc_o, 32'h80);
    check_bubble("both");
    stall_i = 1'b0; redirect_i = 1'b0;
    step();
    check("both_tgt_pc", id_pc_o, 32'h80);
    check("both_tgt_inst", id_inst_o, 32'h1000_0020);

    // misaligned target, then back-to-back aligned redirect
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0022;
    step();
    check("mis_ifpc", pc_o, 32'h20);
    check("mis_flag", {31'd0, misalign_o}, 32'd1);
    redirect_pc_i = 32'h100;
    step();
    check("b2b_ifpc", pc_o, 32'h100);
    check("mis_sticky", {31'd0, misalign_o}, 32'd1);
    check_bubble("b2b");

    // wrap-around at the top of the address space
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    check("wrap_ifpc", pc_o, 32'hFFFF_FFFC);
    redirect_i = 1'b0;
    step();
    check("wrap_idpc", id_pc_o, 32'hFFFF_FFFC);
    check("wrap_ret", id_return_pc_o, 32'd0);
    check("wrap_inst", id_inst_o, 32'h1000_3FFF);
    check("wrap_next_ifpc", pc_o, 32'd0);
    check("wrap_mis_sticky", {31'd0, misalign_o}, 32'd1);
    step();
    check("wrap_after_idpc", id_pc_o, 32'd0);

    // reset while stalled and redirecting
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200; reset_i = 1'b1;
    step();
    check("rst2_ifpc", pc_o, 32'd0);
    check_bubble("rst2");
    check("rst2_misalign", {31'd0, misalign_o}, 32'd0);
    reset_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    check("rst2_addr", {18'd0, irom_addr_o}, 32'd0);
    step();
    check("rst2_run_pc", id_pc_o, 32'd0);
    check("rst2_run_inst", id_inst_o, 32'h1000_0000);
    check("rst2_run_valid", {31'd0, id_valid_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
